// File: rtl/vend_dispenser.sv
// vend_dispenser: actuator back end for the bottle vending machine.
// Queues per-cycle vend/change requests in a 4-entry FIFO. It then drives the
// bottle motor (closed loop on drop_sense, with jam timeout) and the
// coin-return solenoid (one timed pulse per 5 rs coin).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   vend, change[1:0]   request inputs (change: 00 none, 01 5 rs, 10 10 rs, 11 illegal)
//   drop_sense          bottle-passed sensor, sampled only while the motor runs
//   fault_clr           clears sticky flags and resumes from FAULT
//   motor, solenoid     actuator drives
//   busy, done          activity status and one-cycle completion pulse
//   jam, ovf, cmd_err   sticky fault flags
//   vend_count[7:0]     saturating count of successful drops
module vend_dispenser #(
    parameter int unsigned MOTOR_CYCLES = 8,
    parameter int unsigned SOL_CYCLES   = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend,
    input  logic [1:0] change,
    input  logic       drop_sense,
    input  logic       fault_clr,
    output logic       motor,
    output logic       solenoid,
    output logic       busy,
    output logic       done,
    output logic       jam,
    output logic       ovf,
    output logic       cmd_err,
    output logic [7:0] vend_count
);

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned TMR_W  = 8;
    localparam int unsigned COIN_W = 2;
    localparam int unsigned ENT_W  = COIN_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        SOL_ON,
        SOL_GAP,
        FAULT
    } state_t;

    state_t              state;
    logic [TMR_W-1:0]    tmr;
    logic [COIN_W-1:0]   coins;

    logic [ENT_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [COIN_W-1:0]   req_coins;
    logic [ENT_W-1:0]    head;
    logic                push;
    logic                pop;
    logic                push_ok;
    logic                fifo_full;

    // Request decode: illegal code 11 contributes no coins
    always_comb begin
        req_coins = '0;
        case (change)
            2'b01:   req_coins = COIN_W'(1);
            2'b10:   req_coins = COIN_W'(2);
            default: req_coins = '0;
        endcase
    end

    assign push      = vend | (req_coins != '0);
    assign fifo_full = (fifo_cnt == CNT_W'(DEPTH));
    assign pop       = (state == IDLE) && (fifo_cnt != '0);
    // A pop in the same cycle frees a slot, so push is accepted even when full
    assign push_ok   = push && (!fifo_full || pop);
    assign cnt_nxt   = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
    assign head      = fifo_mem[rd_ptr];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {vend, req_coins};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= cnt_nxt;
        end
    end

    // Sticky request flags; a new event in the clearing cycle still sets them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf     <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            if (push && !push_ok) ovf <= 1'b1;
            else if (fault_clr)   ovf <= 1'b0;
            if (change == 2'b11)  cmd_err <= 1'b1;
            else if (fault_clr)   cmd_err <= 1'b0;
        end
    end

    // Sequencer with registered actuator and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            coins      <= '0;
            motor      <= 1'b0;
            solenoid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            jam        <= 1'b0;
            vend_count <= '0;
        end else begin
            done <= 1'b0;
            busy <= 1'b1;
            if (fault_clr) jam <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        coins <= head[COIN_W-1:0];
                        tmr   <= '0;
                        if (head[ENT_W-1]) begin
                            state <= MOTOR;
                            motor <= 1'b1;
                        end else begin
                            state    <= SOL_ON;
                            solenoid <= 1'b1;
                        end
                    end else begin
                        busy <= (cnt_nxt != '0);
                    end
                end
                MOTOR: begin
                    // Drop is checked first so it wins over a same-edge timeout
                    if (drop_sense) begin
                        motor <= 1'b0;
                        if (vend_count != 8'hFF) vend_count <= vend_count + 8'd1;
                        if (coins != '0) begin
                            state    <= SOL_ON;
                            solenoid <= 1'b1;
                            tmr      <= '0;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= (cnt_nxt != '0);
                        end
                    end else if (tmr == TMR_W'(MOTOR_CYCLES - 1)) begin
                        motor <= 1'b0;
                        jam   <= 1'b1;
                        state <= FAULT;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                FAULT: begin
                    // The bottle is not retried; any owed change is still paid
                    if (fault_clr) begin
                        if (coins != '0) begin
                            state    <= SOL_ON;
                            solenoid <= 1'b1;
                            tmr      <= '0;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= (cnt_nxt != '0);
                        end
                    end
                end
                SOL_ON: begin
                    if (tmr == TMR_W'(SOL_CYCLES - 1)) begin
                        solenoid <= 1'b0;
                        state    <= SOL_GAP;
                        tmr      <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                SOL_GAP: begin
                    if (tmr == TMR_W'(GAP_CYCLES - 1)) begin
                        coins <= coins - COIN_W'(1);
                        tmr   <= '0;
                        if (coins != COIN_W'(1)) begin
                            state    <= SOL_ON;
                            solenoid <= 1'b1;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= (cnt_nxt != '0);
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    motor    <= 1'b0;
                    solenoid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: scoreboard bench for vend_dispenser.
// The driver issues one request at a time and pushes the expected outcome of
// each queued command; the monitor measures each command and compares on done.
module tb_vend_dispenser;

    localparam int MC  = 8;
    localparam int SC  = 4;
    localparam int GC  = 2;

    logic       clk;
    logic       rst;
    logic       vend;
    logic [1:0] change;
    logic       drop_sense;
    logic       fault_clr;
    logic       motor;
    logic       solenoid;
    logic       busy;
    logic       done;
    logic       jam;
    logic       ovf;
    logic       cmd_err;
    logic [7:0] vend_count;

    vend_dispenser #(.MOTOR_CYCLES(MC), .SOL_CYCLES(SC), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .vend(vend), .change(change),
        .drop_sense(drop_sense), .fault_clr(fault_clr),
        .motor(motor), .solenoid(solenoid), .busy(busy), .done(done),
        .jam(jam), .ovf(ovf), .cmd_err(cmd_err), .vend_count(vend_count)
    );

    typedef struct {
        int mc;    // motor-high cycles
        int sc;    // solenoid-high cycles
        int sp;    // solenoid pulses
        int jm;    // jam seen during the command
        int vc;    // vend_count at completion
        int span;  // cycles from first actuator activity to done
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   vc_model = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: accumulate per-command activity, compare against scoreboard on done
    int   m_mc, m_sc, m_sp, m_js, m_span;
    bit   in_cmd;
    logic sol_prev;
    exp_t m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_mc = 0; m_sc = 0; m_sp = 0; m_js = 0; m_span = 0;
            in_cmd = 0;
        end else begin
            if (motor) m_mc++;
            if (solenoid) m_sc++;
            if (solenoid && !sol_prev) m_sp++;
            if (jam) m_js = 1;
            if (in_cmd) m_span++;
            else if (motor || solenoid) begin
                in_cmd = 1;
                m_span = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("motor_cycles", m_mc, m_e.mc);
                    check("sol_cycles", m_sc, m_e.sc);
                    check("sol_pulses", m_sp, m_e.sp);
                    check("jam_seen", m_js, m_e.jm);
                    check("vend_count", int'(vend_count), m_e.vc);
                    check("cmd_span", m_span, m_e.span);
                end
                m_mc = 0; m_sc = 0; m_sp = 0; m_js = 0; m_span = 0;
                in_cmd = 0;
            end
        end
        sol_prev = solenoid;
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // One request; d = MOTOR edge that sees drop_sense (> MC means never),
    // w = extra wait in FAULT, extra = 5 rs pushes issued while in FAULT.
    task automatic run_cmd(input bit v, input logic [1:0] ch, input int d,
                           input int w, input int extra);
        int   n;
        int   k;
        exp_t e;
        n = (ch == 2'b01) ? 1 : (ch == 2'b10) ? 2 : 0;
        wait_idle();
        if (v || n != 0) begin
            e.sp = n;
            e.sc = n * SC;
            e.mc = v ? ((d <= MC) ? d : MC) : 0;
            e.jm = (v && d > MC) ? 1 : 0;
            if (v && d <= MC && vc_model < 255) vc_model++;
            e.vc = vc_model;
            if (!v)            e.span = n * (SC + GC);
            else if (d <= MC)  e.span = d + n * (SC + GC);
            else               e.span = 9 + extra + w + n * (SC + GC);
            exp_q.push_back(e);
        end
        vend = v;
        change = ch;
        @(negedge clk);
        vend = 1'b0;
        change = 2'b00;
        if (ch == 2'b11) check("cmd_err_set", cmd_err, 1);
        if (!v && n == 0) begin
            check("illegal_busy", busy, 0);
        end else begin
            check("busy_after_push", busy, 1);
            check("idle_before_pop", motor | solenoid, 0);
            @(negedge clk);
            if (v) begin
                check("motor_start", motor, 1);
                check("sol_in_motor", solenoid, 0);
                if (d <= MC) begin
                    repeat (d - 1) @(negedge clk);
                    drop_sense = 1'b1;
                    @(negedge clk);
                    drop_sense = 1'b0;
                end else begin
                    k = 0;
                    while (!jam && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    check("jam_flag", jam, 1);
                    check("motor_off_fault", motor, 0);
                    for (int i = 0; i < extra; i++) begin
                        if (i < 4) begin
                            e.mc = 0; e.sc = SC; e.sp = 1; e.jm = 0;
                            e.vc = vc_model; e.span = SC + GC;
                            exp_q.push_back(e);
                        end
                        change = 2'b01;
                        @(negedge clk);
                    end
                    change = 2'b00;
                    if (extra > 0) check("ovf_flag", ovf, (extra > 4) ? 1 : 0);
                    repeat (w) @(negedge clk);
                    fault_clr = 1'b1;
                    @(negedge clk);
                    fault_clr = 1'b0;
                    check("jam_cleared", jam, 0);
                    check("ovf_cleared", ovf, 0);
                end
            end else begin
                check("sol_start", solenoid, 1);
            end
        end
        wait_idle();
        if (ch == 2'b11) begin
            fault_clr = 1'b1;
            @(negedge clk);
            fault_clr = 1'b0;
            check("cmd_err_clr", cmd_err, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int   r;
        int   k;
        int   hi_cnt;
        bit   v;
        logic [1:0] ch;
        int   d;
        int   w;
        int   extra;
        logic prev;

        rst = 1'b1;
        vend = 1'b0;
        change = 2'b00;
        drop_sense = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_motor", motor, 0);
        check("rst_solenoid", solenoid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_jam", jam, 0);
        check("rst_ovf", ovf, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_vend_count", int'(vend_count), 0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(1'b1, 2'b00, 3, 0, 0);    // bottle only
        run_cmd(1'b0, 2'b10, 0, 0, 0);    // 10 rs change only
        run_cmd(1'b1, 2'b01, 99, 2, 0);   // jam, then one coin
        run_cmd(1'b1, 2'b01, 99, 1, 5);   // overflow while in FAULT
        run_cmd(1'b0, 2'b11, 0, 0, 0);    // illegal code alone
        run_cmd(1'b1, 2'b11, 2, 0, 0);    // illegal code with bottle
        run_cmd(1'b1, 2'b10, 8, 0, 0);    // drop on the timeout edge
        run_cmd(1'b1, 2'b00, 1, 0, 0);    // immediate drop

        for (int t = 0; t < 40; t++) begin
            v = 1'($urandom % 2);
            ch = 2'($urandom % 4);
            if (!v && ch == 2'b00) v = 1'b1;
            d = int'($urandom_range(1, 10));
            w = int'($urandom_range(0, 3));
            extra = (v && d > MC) ? int'($urandom_range(0, 6)) : 0;
            run_cmd(v, ch, d, w, extra);
        end

        // Asynchronous reset during the second solenoid pulse
        wait_idle();
        change = 2'b10;
        @(negedge clk);
        change = 2'b00;
        r = 0;
        k = 0;
        prev = 1'b0;
        while (r < 2 && k < 40) begin
            @(negedge clk);
            if (solenoid && !prev) r++;
            prev = solenoid;
            k++;
        end
        check("second_pulse_seen", r, 2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_solenoid", solenoid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_vend_count", int'(vend_count), 0);
        exp_q.delete();
        vc_model = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (solenoid || busy || motor) hi_cnt++;
        end
        check("post_rst_quiet", hi_cnt, 0);
        run_cmd(1'b1, 2'b01, 4, 0, 0);

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Actuator back end for the bottle vending machine. It takes the per-cycle vend command (`vend`) and change-return code (`change`) produced by the vending FSM and queues them. It then drives the bottle motor and the coin-return solenoid with timed pulses. Bottle delivery is closed-loop on a drop sensor with jam detection; each 5 rs coin is returned as one open-loop solenoid pulse.

## Interface
- `MOTOR_CYCLES`, default 8: maximum motor-on cycles waiting for `drop_sense` before a jam is declared (1..255).
- `SOL_CYCLES`, default 4: solenoid high cycles per returned 5 rs coin (1..255).
- `GAP_CYCLES`, default 2: solenoid low cycles after each pulse (1..255).

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `vend` input 1: dispense one bottle.
- `change` input 2: 00 none, 01 = 5 rs, 10 = 10 rs, 11 illegal.
- `drop_sense` input 1: bottle-passed sensor, sampled only in MOTOR.
- `fault_clr` input 1: clears `jam`, `ovf` and `cmd_err`, and resumes from FAULT.
- `motor` output 1: bottle motor drive.
- `solenoid` output 1: coin-return solenoid drive.
- `busy` output 1: FIFO non-empty or FSM not IDLE.
- `done` output 1: one-cycle pulse when a command completes.
- `jam` output 1: sticky flag; motor timeout.
- `ovf` output 1: sticky flag; request dropped because the FIFO was full.
- `cmd_err` output 1: sticky flag; `change` = 11 was seen.
- `vend_count` output 8: successful bottle drops, saturating at 255.

## Operation
- Request capture, evaluated every rising edge:
  - Coins = 1 for `change` 01, 2 for 10, 0 otherwise.
  - `change` = 11 sets `cmd_err` and counts as 0 coins.
  - A 3-bit entry {vend, coins} is pushed when `vend` = 1 or coins ≠ 0.
  - A held input pushes once per cycle it is held; no edge detection.
- Command FIFO, 4 entries, first in first out:
  - A push while full with no pop in the same cycle is dropped and sets `ovf`.
  - Simultaneous push and pop are always accepted, including when full.
- FSM states: IDLE, MOTOR, SOL_ON, SOL_GAP, FAULT.
- IDLE:
  - When the FIFO is non-empty, pop into the current-command register.
  - Go to MOTOR if vend = 1, otherwise to SOL_ON.
- MOTOR:
  - `motor` = 1 and the cycle counter increments.
  - If `drop_sense` = 1 on an edge: `vend_count`++ (saturating), then go to SOL_ON if coins > 0, else to IDLE with `done`.
  - On the MOTOR_CYCLES-th edge with no drop: set `jam`, go to FAULT.
  - If drop and timeout occur on the same edge, the drop wins.
- FAULT:
  - `motor` = 0 and `solenoid` = 0.
  - The FIFO still accepts pushes.
  - On `fault_clr`, go to SOL_ON if coins > 0, else to IDLE with `done`. The customer's change is still returned and the bottle is not retried.
- SOL_ON: `solenoid` = 1 for SOL_CYCLES cycles, then go to SOL_GAP.
- SOL_GAP:
  - `solenoid` = 0 for GAP_CYCLES cycles, then decrement coins.
  - If coins remain, go to SOL_ON; otherwise go to IDLE with `done`.
  - The gap also enforces spacing between consecutive commands.
- `fault_clr` outside FAULT clears only the sticky flags.

## Timing
- All outputs are registered.
- Reset values: `motor`, `solenoid`, `busy`, `done`, `jam`, `ovf`, `cmd_err` = 0 and `vend_count` = 0. FIFO empty, FSM in IDLE.
- Reset mid-operation takes effect immediately (asynchronous): actuators drop, the queued command is lost and counters clear.
- Latency: a request sampled at edge k is pushed at edge k. It is popped at edge k+1 if the FIFO was empty and the FSM idle, so `motor` or `solenoid` rises after edge k+1.
- Motor on-time:
  - `motor` is high from the pop edge until the edge that samples `drop_sense` = 1.
  - At most MOTOR_CYCLES cycles, then `motor` goes low together with `jam` rising.
- Coin return for N coins: N × (SOL_CYCLES + GAP_CYCLES) cycles from entering SOL_ON.
- `done` is high for the one cycle after the completing edge. IDLE can pop the next entry on the edge after that.
- `busy` deasserts on the same edge that `done` rises, provided the FIFO is empty.

## Test plan
- Bottle only: `vend`=1 for 1 cycle at edge 0, `drop_sense`=1 at edge 3 → `motor` high over edges 1–3, `done` pulse after edge 3, `vend_count`=1, `solenoid` never high.
- 10 rs change only: `change`=10 for 1 cycle → two 4-cycle solenoid pulses each followed by a 2-cycle gap, `done` 12 cycles after the pop edge, `motor` never high.
- Jam: `vend`=1, `change`=01, no `drop_sense` → `motor` high exactly 8 cycles, `jam`=1, FSM holds in FAULT. `fault_clr` → one solenoid pulse, then `done`, `vend_count`=0, `jam`=0.
- Overflow: hold the FSM in FAULT, then drive `change`=01 for 5 consecutive cycles → 4 entries queued, `ovf`=1. After `fault_clr`, exactly 4 coin pulses beyond the faulted command.
- Illegal code: `change`=11 with `vend`=0 → `cmd_err`=1, nothing queued, `busy` stays 0. `change`=11 with `vend`=1 → bottle cycle only.
- Async reset during the second SOL_ON pulse → `solenoid`, `busy` and `done` = 0 immediately. After release, no further pulses and FIFO empty.
